dispatch_unit: RTL

DISPATCH_UNIT -- requirements
Module: dispatch_unit

---
 rtl/dispatch_unit_pkg.sv | 25 ++
 rtl/dispatch_fifo.sv | 65 ++++++
 rtl/dispatch_unit.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/dispatch_unit_pkg.sv
// Shared constants for the dispatch unit: RV32I opcodes, target-unit codes, default ROB tag width.
// Revision: 1.0
`default_nettype none

package dispatch_unit_pkg;

  localparam int DEFAULT_ROB_WIDTH_BIT = 5;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [1:0] UNIT_ROB = 2'd0;
  localparam logic [1:0] UNIT_RS  = 2'd1;
  localparam logic [1:0] UNIT_LSB = 2'd2;

endpackage

`default_nettype wire

// File: rtl/dispatch_fifo.sv
// Instruction queue: power-of-two circular buffer with occupancy count and full/empty flags.
// Revision: 1.0
`default_nettype none

module dispatch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = en && !flush && push && !full;
  assign do_pop  = en && !flush && pop && !empty;
  assign rdata   = mem[head];

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (en) begin
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (do_push) tail <= tail + 1'b1;
        if (do_pop)  head <= head + 1'b1;
        case ({do_push, do_pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[tail] <= wdata;
  end

endmodule

`default_nettype wire

// File: rtl/dispatch_unit.sv
// Decodes the instruction-queue head, gathers operands and issues it to the ROB, RS or LSB.
// Revision: 1.0
`default_nettype none

module dispatch_unit
  import dispatch_unit_pkg::*;
#(
  parameter int IQ_DEPTH      = 4,
  parameter int ROB_WIDTH_BIT = DEFAULT_ROB_WIDTH_BIT
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       rdy_in,
  input  logic                       if_valid,
  input  logic [31:0]                if_ins,
  input  logic [31:0]                if_pc,
  output logic                       if_ready,
  input  logic                       flush,
  input  logic                       rob_ready,
  input  logic [ROB_WIDTH_BIT-1:0]   rob_tag,
  input  logic                       rs_ready,
  input  logic                       lsb_ready,
  output logic [4:0]                 rf_rs1,
  output logic [4:0]                 rf_rs2,
  input  logic [31:0]                rf_val1,
  input  logic [31:0]                rf_val2,
  input  logic                       rf_dep1,
  input  logic                       rf_dep2,
  input  logic [ROB_WIDTH_BIT-1:0]   rf_tag1,
  input  logic [ROB_WIDTH_BIT-1:0]   rf_tag2,
  output logic                       disp_valid,
  output logic [1:0]                 disp_unit,
  output logic [6:0]                 disp_opcode,
  output logic [2:0]                 disp_funct3,
  output logic                       disp_f7b,
  output logic [4:0]                 disp_rd,
  output logic [31:0]                disp_imm,
  output logic [31:0]                disp_pc,
  output logic [31:0]                disp_v1,
  output logic [31:0]                disp_v2,
  output logic                       disp_h1,
  output logic                       disp_h2,
  output logic [ROB_WIDTH_BIT-1:0]   disp_q1,
  output logic [ROB_WIDTH_BIT-1:0]   disp_q2,
  output logic [ROB_WIDTH_BIT-1:0]   disp_tag,
  output logic [$clog2(IQ_DEPTH):0]  iq_count
);

  logic [63:0] head_entry;
  logic        full;
  logic        empty;
  logic [31:0] ins;
  logic [31:0] pc;
  logic [6:0]  opcode;
  logic [1:0]  unit;
  logic        known;
  logic        use1;
  logic        use2;
  logic [31:0] imm;
  logic [31:0] v1;
  logic [31:0] v2;
  logic        h1;
  logic        h2;
  logic [ROB_WIDTH_BIT-1:0] q1;
  logic [ROB_WIDTH_BIT-1:0] q2;
  logic        target_ready;
  logic        pop_ok;
  logic        dispatch;

  dispatch_fifo #(
    .DEPTH (IQ_DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk   (clk_in),
    .rst   (rst_in),
    .en    (rdy_in),
    .flush (flush),
    .push  (if_valid),
    .pop   (pop_ok),
    .wdata ({if_ins, if_pc}),
    .rdata (head_entry),
    .count (iq_count),
    .full  (full),
    .empty (empty)
  );

  assign if_ready = !full;
  assign ins      = head_entry[63:32];
  assign pc       = head_entry[31:0];
  assign opcode   = ins[6:0];
  assign rf_rs1   = ins[19:15];
  assign rf_rs2   = ins[24:20];

  always_comb begin
    unit  = UNIT_ROB;
    known = 1'b1;
    use1  = 1'b0;
    use2  = 1'b0;
    imm   = '0;
    case (opcode)
      OP_LUI, OP_AUIPC: imm = {ins[31:12], 12'b0};
      OP_JAL:    imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      OP_JALR:   begin unit = UNIT_RS;  use1 = 1'b1; imm = {{20{ins[31]}}, ins[31:20]}; end
      OP_BRANCH: begin
        unit = UNIT_RS; use1 = 1'b1; use2 = 1'b1;
        imm  = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      OP_LOAD:   begin unit = UNIT_LSB; use1 = 1'b1; imm = {{20{ins[31]}}, ins[31:20]}; end
      OP_STORE:  begin
        unit = UNIT_LSB; use1 = 1'b1; use2 = 1'b1;
        imm  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      end
      OP_IMM:    begin unit = UNIT_RS;  use1 = 1'b1; imm = {{20{ins[31]}}, ins[31:20]}; end
      OP_REG:    begin unit = UNIT_RS;  use1 = 1'b1; use2 = 1'b1; end
      default:   known = 1'b0;
    endcase
  end

  // ROB-only ops carry their result in v1 so the ROB can retire them directly.
  always_comb begin
    v1 = '0;
    h1 = 1'b0;
    q1 = '0;
    v2 = '0;
    h2 = 1'b0;
    q2 = '0;
    if (use1 && rf_rs1 != 5'd0) begin
      v1 = rf_val1;
      h1 = rf_dep1;
      q1 = rf_tag1;
    end
    if (use2 && rf_rs2 != 5'd0) begin
      v2 = rf_val2;
      h2 = rf_dep2;
      q2 = rf_tag2;
    end
    case (opcode)
      OP_LUI:   v1 = imm;
      OP_AUIPC: v1 = pc + imm;
      OP_JAL:   v1 = pc + 32'd4;
      default:  ;
    endcase
  end

  always_comb begin
    case (unit)
      UNIT_RS:  target_ready = rs_ready;
      UNIT_LSB: target_ready = lsb_ready;
      default:  target_ready = 1'b1;
    endcase
  end

  // Unknown opcodes are drained without needing a ROB slot.
  assign pop_ok   = !empty && (!known || (rob_ready && target_ready));
  assign dispatch = pop_ok && known && rdy_in && !flush;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      disp_valid  <= 1'b0;
      disp_unit   <= '0;
      disp_opcode <= '0;
      disp_funct3 <= '0;
      disp_f7b    <= 1'b0;
      disp_rd     <= '0;
      disp_imm    <= '0;
      disp_pc     <= '0;
      disp_v1     <= '0;
      disp_v2     <= '0;
      disp_h1     <= 1'b0;
      disp_h2     <= 1'b0;
      disp_q1     <= '0;
      disp_q2     <= '0;
      disp_tag    <= '0;
    end else if (rdy_in) begin
      disp_valid <= dispatch;
      if (dispatch) begin
        disp_unit   <= unit;
        disp_opcode <= opcode;
        disp_funct3 <= ins[14:12];
        disp_f7b    <= ins[30];
        disp_rd     <= ins[11:7];
        disp_imm    <= imm;
        disp_pc     <= pc;
        disp_v1     <= v1;
        disp_v2     <= v2;
        disp_h1     <= h1;
        disp_h2     <= h2;
        disp_q1     <= q1;
        disp_q2     <= q2;
        disp_tag    <= rob_tag;
      end
    end
  end

endmodule

`default_nettype wire
